// File: rtl/pwm_mc_core.sv
// Multi-channel PWM counter/compare engine. Configuration is shadowed and only
// becomes active at a period boundary (or at once while the counter is stopped).
module pwm_mc_core #(
  parameter int CHN_NUM   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PSC_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic                         mode_i,
  input  logic [PSC_WIDTH-1:0]         psc_i,
  input  logic [CNT_WIDTH-1:0]         cmp_i,
  input  logic [CHN_NUM*CNT_WIDTH-1:0] cr_i,
  input  logic [CHN_NUM-1:0]           pol_i,
  input  logic                         upd_i,
  input  logic                         irq_en_i,
  input  logic                         irq_clr_i,
  output logic [CNT_WIDTH-1:0]         cnt_o,
  output logic [CHN_NUM-1:0]           pwm_o,
  output logic                         ovf_o,
  output logic                         upd_done_o,
  output logic                         irq_o
);

  logic                              r_mode;
  logic [PSC_WIDTH-1:0]              r_psc;
  logic [CNT_WIDTH-1:0]              r_cmp;
  logic [CHN_NUM-1:0][CNT_WIDTH-1:0] r_cr;
  logic [CHN_NUM-1:0]                r_pol;
  logic [PSC_WIDTH-1:0]              r_psc_cnt;
  logic [CNT_WIDTH-1:0]              r_cnt;
  logic                              r_dir_dn;
  logic                              r_upd_pend;
  logic                              r_ovf;
  logic                              r_upd_done;
  logic                              r_irq;

  logic                 w_tick;
  logic                 w_bnd;
  logic                 w_load;
  logic [CNT_WIDTH-1:0] w_cnt_nx;
  logic                 w_dir_dn_nx;

  assign w_tick = en_i & (r_psc_cnt == r_psc);

  // Next count on a tick, and whether that tick closes the period.
  always_comb begin
    w_cnt_nx    = r_cnt;
    w_dir_dn_nx = r_dir_dn;
    w_bnd       = 1'b0;
    if (!r_mode) begin
      if (r_cnt >= r_cmp) begin
        w_cnt_nx = '0;
        w_bnd    = 1'b1;
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
    end else if (r_cmp == '0) begin
      w_cnt_nx    = '0;
      w_dir_dn_nx = 1'b0;
      w_bnd       = 1'b1;
    end else if (!r_dir_dn && (r_cnt < r_cmp)) begin
      w_cnt_nx = r_cnt + 1'b1;
    end else begin
      // Turning at the top (cmp=1 lands straight on 0) or descending.
      w_cnt_nx    = r_dir_dn ? (r_cnt - 1'b1) : (r_cmp - 1'b1);
      w_bnd       = (w_cnt_nx == '0);
      w_dir_dn_nx = ~w_bnd;
    end
  end

  assign w_load = r_upd_pend & (en_i ? (w_tick & w_bnd) : 1'b1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_mode     <= 1'b0;
      r_psc      <= '0;
      r_cmp      <= '0;
      r_cr       <= '0;
      r_pol      <= '0;
      r_psc_cnt  <= '0;
      r_cnt      <= '0;
      r_dir_dn   <= 1'b0;
      r_upd_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_upd_done <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ovf      <= w_tick & w_bnd;
      r_upd_done <= w_load;
      r_irq      <= (r_ovf & irq_en_i) | (r_irq & ~irq_clr_i);
      if (w_load) begin
        // A load always restarts the period, so a smaller cmp can never be overrun.
        r_mode     <= mode_i;
        r_psc      <= psc_i;
        r_cmp      <= cmp_i;
        r_cr       <= cr_i;
        r_pol      <= pol_i;
        r_upd_pend <= 1'b0;
        r_cnt      <= '0;
        r_dir_dn   <= 1'b0;
        r_psc_cnt  <= '0;
      end else begin
        if (upd_i) r_upd_pend <= 1'b1;
        if (!en_i) begin
          r_psc_cnt <= '0;
        end else if (w_tick) begin
          r_psc_cnt <= '0;
          r_cnt     <= w_cnt_nx;
          r_dir_dn  <= w_dir_dn_nx;
        end else begin
          r_psc_cnt <= r_psc_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHN_NUM; g++) begin : g_ch
    assign pwm_o[g] = (r_cnt < r_cr[g]) ^ r_pol[g];
  end

  assign cnt_o      = r_cnt;
  assign ovf_o      = r_ovf;
  assign upd_done_o = r_upd_done;
  assign irq_o      = r_irq;

endmodule

// File: doc/pwm_mc_core.md
Name: pwm_mc_core

Overview:
Multi-channel PWM timer core: the next generation of the APB4 PWM counter/compare engine, to be instantiated behind an APB4 register wrapper. Generalised to CHN_NUM channels and parametrised widths. Adds center-aligned mode, per-channel polarity, shadowed configuration loaded only at the period boundary, and an explicit overflow pulse with pending IRQ. Single clock domain; the prescaler is a tick enable, not a derived clock.

Parameters:
CHN_NUM, 4, number of PWM output channels (1..16)
CNT_WIDTH, 16, counter/compare width in bits
PSC_WIDTH, 16, prescaler width in bits

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
en_i  in  1  counter enable
mode_i  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
psc_i  in  PSC_WIDTH  prescaler; tick every psc+1 clk (shadowed)
cmp_i  in  CNT_WIDTH  period top value (shadowed)
cr_i  in  CHN_NUM*CNT_WIDTH  per-channel compare, channel i at [i*CNT_WIDTH +: CNT_WIDTH] (shadowed)
pol_i  in  CHN_NUM  per-channel output inversion (shadowed)
upd_i  in  1  request shadow load, 1-clk pulse
irq_en_i  in  1  overflow IRQ enable
irq_clr_i  in  1  clear IRQ pending, 1-clk pulse
cnt_o  out  CNT_WIDTH  current counter value
pwm_o  out  CHN_NUM  PWM outputs
ovf_o  out  1  period-boundary pulse
upd_done_o  out  1  shadow-load pulse
irq_o  out  1  IRQ pending

Behaviour:
- Reset (synchronous, rst_n_i=0 at a clk_i edge) clears all state: cnt=0, dir=up, prescaler=0, active regs 0, upd_pend=0, irq pend=0. Outputs after reset: cnt_o=0, ovf_o=0, upd_done_o=0, irq_o=0, pwm_o=0. A reset mid-period discards any pending update.
- Active regs (mode, psc, cmp, cr[], pol) drive all behaviour. Config inputs are sampled only at load time; software must hold them stable until upd_done_o.
- upd_i sets upd_pend. The load occurs on the boundary tick, or on the next clk if en_i=0. On load: active regs take the inputs, upd_pend clears, and upd_done_o pulses 1 clk, registered and coincident with the new cnt_o. upd_i during pending: no additional effect. upd_i coincident with a load: consumed by that load.
- Prescaler: psc_cnt counts 0..psc_q while en_i=1. tick = en_i & (psc_cnt==psc_q), and psc_cnt then wraps to 0. psc_q=0 gives a tick every clk. en_i=0: psc_cnt cleared; cnt and dir held.
- Edge mode, on tick: if cnt>=cmp_q then cnt=0 (boundary), else cnt+1. Period is cmp+1 ticks.
- Center mode, on tick:
  - Up: cnt+1 until cnt==cmp_q, then dir=down and cnt=cmp_q-1.
  - Down: cnt-1. Reaching 0 is the boundary, and dir becomes up.
  - Period is 2*cmp ticks.
  - cmp_q=0: cnt stays 0 and every tick is a boundary.
  - A mode change via load restarts at cnt=0, dir=up.
- A cmp reduced below the current cnt is only possible via load, which happens with cnt=0; there is no wrap hazard.
- pwm_o[i] = (cnt_q < cr_q[i]) XOR pol_q[i], combinational from registers; no extra latency versus cnt_o.
  - cr=0: 0% duty. cr>cmp (edge) or cr>cmp (center): 100%.
- ovf_o: 1-clk pulse, registered, in the cycle cnt_o first shows 0 of a new period.
- IRQ pend: set when ovf_o & irq_en_i; cleared by irq_clr_i. Set wins over a simultaneous clear. irq_o = pend.
- Counter arithmetic is modulo CNT_WIDTH. Comparisons are unsigned. No overflow is possible because cnt never exceeds cmp_q.

Test Plan:
- Edge, psc=0, cmp=4, cr0=2, pol=0, upd, en -> cnt 0,1,2,3,4,0…; pwm_o[0] high 2 of every 5 clk; ovf_o every 5 clk; upd_done_o once.
- Center, cmp=3, cr0=2, psc=0 -> cnt 0,1,2,3,2,1,0…; pwm_o[0] high at cnt 0,1 (3 of 6 clk); ovf_o every 6 clk.
- psc=2, edge, cmp=1 -> cnt changes every 3 clk; period 6 clk; en_i low for 4 clk holds cnt, and on resume the count restarts with a full 3-clk prescale.
- Mid-period write cmp 4->7 with upd at cnt=2 -> the old period completes; upd_done_o and ovf_o fire together with cnt=0; the next period is 8 ticks.
- cr0=0, cr1=9 (cmp=4), pol2=1, cr2=2 -> pwm0 constantly 0, pwm1 constantly 1, pwm2 the inverse of the edge waveform.
- irq_en=1: irq_o rises 1 clk after ovf_o; irq_clr on the same clk as ovf_o keeps irq_o=1; a later lone irq_clr gives 0; rst_n_i low mid-period gives all outputs 0 the next clk.
